// File: rtl/beta_mem_pkg.sv
// ============================================================================
// Module   : beta_mem_pkg
// Purpose  : Shared types and constants for the Beta CPU memory request path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package beta_mem_pkg;

    localparam int DWIDTH_DEFAULT = 32;
    localparam int AWIDTH_DEFAULT = 16;

    // Controller RW encoding; the controller's write enable is ~RW.
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT_LO = 3'd2,
        WAIT_HI = 3'd3,
        DONE    = 3'd4
    } mem_state_t;

endpackage

`default_nettype wire

// File: rtl/mem_wait_timer.sv
// ============================================================================
// Module   : mem_wait_timer
// Purpose  : Saturating wait counter with clear/enable; flags the final cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wait_timer #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != CW'(LIMIT))) begin
            count <= count + 1'b1;
        end
    end

    // Asserted during the last allowed wait cycle so the FSM leaves on the
    // edge where the count would reach LIMIT.
    assign expired = (count >= CW'(LIMIT - 1));

endmodule

`default_nettype wire

// File: rtl/mem_request_initiator.sv
// ============================================================================
// Module   : mem_request_initiator
// Purpose  : CPU-side initiator for the Valid/RW/Addr/Ready memory protocol.
//            Optional wait timeout enabled by defining MEM_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_request_initiator
    import beta_mem_pkg::*;
#(
    parameter int DWIDTH         = DWIDTH_DEFAULT,
    parameter int AWIDTH         = AWIDTH_DEFAULT,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [AWIDTH-1:0] cpu_addr,
    input  logic [DWIDTH-1:0] cpu_wdata,
    output logic              cpu_busy,
    output logic              cpu_done,
    output logic [DWIDTH-1:0] cpu_rdata,
    output logic              cpu_err,
    output logic              mem_valid,
    output logic              mem_rw,
    output logic [AWIDTH-1:0] mem_addr,
    input  logic              mem_ready,
    output logic [DWIDTH-1:0] mem_data_out,
    output logic              mem_data_oe,
    input  logic [DWIDTH-1:0] mem_data_in
);

    mem_state_t state;
    mem_state_t state_nxt;
    logic       timed_out;

`ifdef MEM_TIMEOUT_EN
    logic timer_expired;

    mem_wait_timer #(
        .LIMIT   (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state == ISSUE),
        .enable  ((state == WAIT_LO) || (state == WAIT_HI)),
        .expired (timer_expired)
    );

    // Timeout only wins when the normal Ready transition is not happening.
    assign timed_out = timer_expired &&
                       (((state == WAIT_LO) && mem_ready) ||
                        ((state == WAIT_HI) && !mem_ready));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_err <= 1'b0;
        end else begin
            cpu_err <= timed_out;
        end
    end
`else
    // The timeout limit has no effect without the timer.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign timed_out          = 1'b0;
    assign cpu_err            = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cpu_req) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT_LO;
            WAIT_LO: begin
                if (!mem_ready) begin
                    state_nxt = WAIT_HI;
                end else if (timed_out) begin
                    state_nxt = DONE;
                end
            end
            WAIT_HI: begin
                if (mem_ready || timed_out) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request fields are registered on the accept edge so they are already
    // presented during ISSUE and stay frozen until the DONE exit edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid    <= 1'b0;
            mem_rw       <= RW_READ;
            mem_addr     <= '0;
            mem_data_out <= '0;
            mem_data_oe  <= 1'b0;
            cpu_rdata    <= '0;
        end else begin
            mem_valid <= (state == IDLE) && cpu_req;
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        mem_rw      <= cpu_we ? RW_WRITE : RW_READ;
                        mem_addr    <= cpu_addr;
                        mem_data_oe <= cpu_we;
                        if (cpu_we) begin
                            mem_data_out <= cpu_wdata;
                        end
                    end
                end
                WAIT_LO: begin
                    if (state_nxt == DONE) begin
                        mem_data_oe <= 1'b0;
                    end
                end
                WAIT_HI: begin
                    if (state_nxt == DONE) begin
                        mem_data_oe <= 1'b0;
                    end
                    if (mem_ready && (mem_rw == RW_READ)) begin
                        cpu_rdata <= mem_data_in;
                    end
                end
                DONE:    mem_rw <= RW_READ;
                default: ;
            endcase
        end
    end

    assign cpu_busy = (state != IDLE);
    assign cpu_done = (state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_mem_request_initiator.sv
// ============================================================================
// Module   : tb_mem_request_initiator
// Purpose  : Self-checking bench for mem_request_initiator with a cycle-level
//            Ready/data controller model and a transaction-level reference.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_request_initiator;

    localparam int DW   = 32;
    localparam int AW   = 16;
    localparam int TMO  = 8;
    localparam int MAXC = 256;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_busy, cpu_done, cpu_err;
    logic [DW-1:0] cpu_rdata;
    logic          mem_valid, mem_rw, mem_data_oe;
    logic [AW-1:0] mem_addr;
    logic          mem_ready = 1'b1;
    logic [DW-1:0] mem_data_out;
    logic [DW-1:0] mem_data_in = '0;

    int            tests_run = 0;
    int            tests_failed = 0;
    logic [DW-1:0] exp_rdata = '0;

    // Per-cycle trace of one transaction, index 0 = ISSUE cycle.
    logic          tr_valid [0:MAXC-1];
    logic          tr_busy  [0:MAXC-1];
    logic          tr_rw    [0:MAXC-1];
    logic          tr_oe    [0:MAXC-1];
    logic          tr_done  [0:MAXC-1];
    logic          tr_err   [0:MAXC-1];
    logic [AW-1:0] tr_addr  [0:MAXC-1];
    logic [DW-1:0] tr_dout  [0:MAXC-1];
    logic [DW-1:0] tr_rdata [0:MAXC-1];
    int            tr_len;
    int            done_at;

    mem_request_initiator #(
        .DWIDTH         (DW),
        .AWIDTH         (AW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_busy     (cpu_busy),
        .cpu_done     (cpu_done),
        .cpu_rdata    (cpu_rdata),
        .cpu_err      (cpu_err),
        .mem_valid    (mem_valid),
        .mem_rw       (mem_rw),
        .mem_addr     (mem_addr),
        .mem_ready    (mem_ready),
        .mem_data_out (mem_data_out),
        .mem_data_oe  (mem_data_oe),
        .mem_data_in  (mem_data_in)
    );

    always #5 clk = ~clk;

    // Controller model: Ready is low for cycles 1+lo_w .. 1+lo_w+hi_w after
    // ISSUE, otherwise high (or permanently high when stuck_high is set).
    // Called at a negedge; returns at the negedge one cycle after cpu_done.
    task automatic run_txn(input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input int lo_w,
                           input int hi_w, input logic [DW-1:0] rd,
                           input bit busy_req, input int budget,
                           input bit stuck_high);
        done_at   = -1;
        tr_len    = 0;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        mem_ready = 1'b1;
        for (int j = 0; j < budget && j < MAXC; j++) begin
            @(negedge clk);
            tr_valid[j] = mem_valid;
            tr_busy[j]  = cpu_busy;
            tr_rw[j]    = mem_rw;
            tr_oe[j]    = mem_data_oe;
            tr_done[j]  = cpu_done;
            tr_err[j]   = cpu_err;
            tr_addr[j]  = mem_addr;
            tr_dout[j]  = mem_data_out;
            tr_rdata[j] = cpu_rdata;
            tr_len      = j + 1;
            if (done_at < 0 && cpu_done) done_at = j;
            if (done_at >= 0 && j == done_at + 1) break;
            if (busy_req) begin
                cpu_req   = 1'b1;
                cpu_we    = ~we;
                cpu_addr  = 16'h0044;
                cpu_wdata = ~wdata;
            end else begin
                cpu_req = 1'b0;
            end
            mem_ready   = stuck_high || !(j >= 1 + lo_w && j <= 1 + lo_w + hi_w);
            mem_data_in = mem_ready ? rd : DW'($urandom);
        end
        cpu_req   = 1'b0;
        mem_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({mem_valid, mem_rw, mem_data_oe, cpu_busy, cpu_done, cpu_err} !== 6'b010000) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b expected 010000",
                     {mem_valid, mem_rw, mem_data_oe, cpu_busy, cpu_done, cpu_err});
        end
        tests_run++;
        if ({mem_addr, mem_data_out, cpu_rdata} !== '0) begin
            tests_failed++;
            $display("FAIL reset_data: addr %h dout %h rdata %h expected all 0",
                     mem_addr, mem_data_out, cpu_rdata);
        end
        cpu_req = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (cpu_busy !== 1'b0 || mem_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_hold: busy %b valid %b expected 0 0", cpu_busy, mem_valid);
        end
        cpu_req = 1'b0;
        rst_n   = 1'b1;
        @(negedge clk);
        exp_rdata = '0;
    endtask

    task automatic test_load();
        run_txn(1'b0, 16'h0012, 32'h0, 0, 2, 32'hDEADBEEF, 1'b0, 64, 1'b0);
        exp_rdata = 32'hDEADBEEF;
        tests_run++;
        if (done_at != 5) begin
            tests_failed++;
            $display("FAIL load_latency: got %0d expected 5", done_at);
        end else begin
            for (int j = 0; j <= done_at; j++) begin
                tests_run++;
                if (tr_valid[j] !== (j == 0) || tr_rw[j] !== 1'b1 || tr_addr[j] !== 16'h0012) begin
                    tests_failed++;
                    $display("FAIL load_bus cyc%0d: valid %b rw %b addr %h expected %b 1 0012",
                             j, tr_valid[j], tr_rw[j], tr_addr[j], (j == 0));
                end
            end
            tests_run++;
            if (tr_rdata[done_at] !== 32'hDEADBEEF || tr_err[done_at] !== 1'b0) begin
                tests_failed++;
                $display("FAIL load_rdata: got %h err %b expected deadbeef err 0",
                         tr_rdata[done_at], tr_err[done_at]);
            end
        end
    endtask

    task automatic test_store();
        run_txn(1'b1, 16'h00FF, 32'h12345678, 1, 1, 32'hA5A5A5A5, 1'b0, 64, 1'b0);
        tests_run++;
        if (done_at != 5) begin
            tests_failed++;
            $display("FAIL store_latency: got %0d expected 5", done_at);
        end else begin
            for (int j = 0; j <= done_at; j++) begin
                tests_run++;
                if (tr_rw[j] !== 1'b0 || tr_oe[j] !== (j < done_at) ||
                    tr_dout[j] !== 32'h12345678 || tr_addr[j] !== 16'h00FF) begin
                    tests_failed++;
                    $display("FAIL store_bus cyc%0d: rw %b oe %b dout %h addr %h expected 0 %b 12345678 00ff",
                             j, tr_rw[j], tr_oe[j], tr_dout[j], tr_addr[j], (j < done_at));
                end
            end
            tests_run++;
            if (tr_rdata[done_at + 1] !== exp_rdata || tr_rw[done_at + 1] !== 1'b1) begin
                tests_failed++;
                $display("FAIL store_after: rdata %h rw %b expected %h 1",
                         tr_rdata[done_at + 1], tr_rw[done_at + 1], exp_rdata);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int vcount = 0;
        run_txn(1'b0, 16'h0033, 32'h0, 1, 1, 32'h0BADF00D, 1'b1, 64, 1'b0);
        exp_rdata = 32'h0BADF00D;
        for (int j = 0; j < tr_len; j++) if (tr_valid[j]) vcount++;
        tests_run++;
        if (vcount != 1 || done_at != 5) begin
            tests_failed++;
            $display("FAIL busy_valid_count: valids %0d done %0d expected 1 5", vcount, done_at);
        end
        for (int j = 0; j < tr_len; j++) begin
            tests_run++;
            if (tr_addr[j] !== 16'h0033) begin
                tests_failed++;
                $display("FAIL busy_addr cyc%0d: got %h expected 0033", j, tr_addr[j]);
            end
        end
        @(negedge clk);
        tests_run++;
        if (cpu_busy !== 1'b0 || mem_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_not_queued: busy %b valid %b expected 0 0", cpu_busy, mem_valid);
        end
    endtask

    // Random back-to-back transactions against the transaction-level model.
    task automatic test_random();
        for (int t = 0; t < 20; t++) begin
            logic          we;
            logic [AW-1:0] addr;
            logic [DW-1:0] wdata, rd;
            int            lo, hi, exp_done;
            logic [5:0]    obs, exp;
            we       = 1'($urandom);
            addr     = AW'($urandom);
            wdata    = DW'($urandom);
            rd       = DW'($urandom);
            lo       = $urandom_range(0, 2);
            hi       = $urandom_range(0, 3);
            exp_done = 3 + lo + hi;
            run_txn(we, addr, wdata, lo, hi, rd, 1'b0, 64, 1'b0);
            if (!we) exp_rdata = rd;
            tests_run++;
            if (done_at != exp_done) begin
                tests_failed++;
                $display("FAIL rand%0d_latency: got %0d expected %0d", t, done_at, exp_done);
            end else begin
                for (int j = 0; j <= exp_done + 1; j++) begin
                    obs = {tr_valid[j], tr_busy[j], tr_rw[j], tr_oe[j], tr_done[j], tr_err[j]};
                    exp = {(j == 0), (j <= exp_done), ((j <= exp_done) ? ~we : 1'b1),
                           (we && j < exp_done), (j == exp_done), 1'b0};
                    tests_run++;
                    if (obs !== exp) begin
                        tests_failed++;
                        $display("FAIL rand%0d_ctrl cyc%0d: got %b expected %b", t, j, obs, exp);
                    end
                    if (j <= exp_done) begin
                        tests_run++;
                        if (tr_addr[j] !== addr || (we && tr_dout[j] !== wdata)) begin
                            tests_failed++;
                            $display("FAIL rand%0d_bus cyc%0d: addr %h dout %h expected %h %h",
                                     t, j, tr_addr[j], tr_dout[j], addr, wdata);
                        end
                    end
                end
                tests_run++;
                if (tr_rdata[exp_done] !== exp_rdata) begin
                    tests_failed++;
                    $display("FAIL rand%0d_rdata: got %h expected %h", t, tr_rdata[exp_done], exp_rdata);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        int saw_done = 0;
        cpu_req   = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = 16'h0123;
        mem_ready = 1'b1;
        @(negedge clk);
        cpu_req   = 1'b0;
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        tests_run++;
        if (cpu_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_busy: got %b expected 1", cpu_busy);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({mem_valid, mem_rw, mem_data_oe, cpu_busy, cpu_done, cpu_err} !== 6'b010000 ||
            {mem_addr, mem_data_out, cpu_rdata} !== '0) begin
            tests_failed++;
            $display("FAIL midrst_async: ctrl %b addr %h dout %h rdata %h expected 010000 0 0 0",
                     {mem_valid, mem_rw, mem_data_oe, cpu_busy, cpu_done, cpu_err},
                     mem_addr, mem_data_out, cpu_rdata);
        end
        exp_rdata = '0;
        mem_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (cpu_done) saw_done++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (cpu_done) saw_done++;
            tests_run++;
            if (cpu_busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL midrst_idle: busy %b expected 0", cpu_busy);
            end
        end
        tests_run++;
        if (saw_done != 0) begin
            tests_failed++;
            $display("FAIL midrst_no_done: got %0d done pulses expected 0", saw_done);
        end
        run_txn(1'b0, 16'h0200, 32'h0, 0, 1, 32'hCAFEF00D, 1'b0, 64, 1'b0);
        exp_rdata = 32'hCAFEF00D;
        tests_run++;
        if (done_at != 4 || tr_rdata[4] !== 32'hCAFEF00D) begin
            tests_failed++;
            $display("FAIL midrst_recover: done %0d rdata %h expected 4 cafef00d",
                     done_at, (done_at >= 0) ? tr_rdata[done_at] : 32'h0);
        end
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        run_txn(1'b0, 16'h0777, 32'h0, 0, 0, 32'h55AA55AA, 1'b0, 40, 1'b1);
        tests_run++;
        if (done_at != 1 + TMO) begin
            tests_failed++;
            $display("FAIL timeout_latency: got %0d expected %0d", done_at, 1 + TMO);
        end else begin
            tests_run++;
            if (tr_err[done_at] !== 1'b1 || tr_err[done_at + 1] !== 1'b0 ||
                tr_busy[done_at + 1] !== 1'b0) begin
                tests_failed++;
                $display("FAIL timeout_err: err %b/%b busy_after %b expected 1/0 0",
                         tr_err[done_at], tr_err[done_at + 1], tr_busy[done_at + 1]);
            end
            tests_run++;
            if (tr_rdata[done_at] !== exp_rdata) begin
                tests_failed++;
                $display("FAIL timeout_rdata: got %h expected %h", tr_rdata[done_at], exp_rdata);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_store();
        test_busy_ignore();
        test_random();
        test_mid_reset();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
